// File: rtl/subneg_pkg.sv
// subneg_pkg: shared loader state, field-index type and instruction width
package subneg_pkg;
  localparam int WORD_W = 8;
  localparam int INSTR_W = 3 * WORD_W;
  typedef enum logic [2:0] {
    ROM_LEN,
    ROM_FIELD,
    DATA_LEN,
    DATA_WORD,
    CHK,
    DONE,
    ERR
  } ld_state_e;
  typedef logic [1:0] fld_t;
endpackage

// File: rtl/subneg_cksum.sv
// subneg_cksum: WIDTH-bit wrapping accumulator with clear and add-enable
//   clk, rst (async active-low), clr_i, en_i, d_i -> sum_o (current total)
module subneg_cksum #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] sum_o
);
  logic [WIDTH-1:0] sum_q;
  assign sum_o = sum_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) sum_q <= '0;
    else if (clr_i) sum_q <= '0;
    else if (en_i) sum_q <= sum_q + d_i;
endmodule

// File: rtl/subneg_loader.sv
// subneg_loader: boot loader writing the subneg ROM and data memory from a word stream
//   stream in: in_valid/in_ready/in_data; start re-arms from DONE/ERR
//   ROM write: rom_we/rom_addr/rom_wdata ({A,B,C}); data write: mem_we/mem_addr/mem_wdata
//   status: core_hold, done, err (all registered)
module subneg_loader
  import subneg_pkg::*;
#(
  parameter int WIDTH      = WORD_W,
  parameter int ROM_DEPTH  = 64,
  parameter int DATA_DEPTH = 128
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               start,
  output logic               rom_we,
  output logic [WIDTH-1:0]   rom_addr,
  output logic [3*WIDTH-1:0] rom_wdata,
  output logic               mem_we,
  output logic [WIDTH-1:0]   mem_addr,
  output logic [WIDTH-1:0]   mem_wdata,
  output logic               core_hold,
  output logic               done,
  output logic               err
);
  ld_state_e state_q, state_d;
  fld_t fld_q, fld_d;
  logic [WIDTH-1:0] cnt_q, cnt_d, len_q, len_d, a_q, a_d, b_q, b_d, sum, sum_nx;
  logic [WIDTH-1:0] rom_addr_q, rom_addr_d, mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3*WIDTH-1:0] rom_wdata_q, rom_wdata_d;
  logic rom_we_q, rom_we_d, mem_we_q, mem_we_d, hold_q, hold_d, done_q, done_d, err_q, err_d;
  logic acc, clr;
  assign in_ready = state_q != DONE && state_q != ERR;
  assign acc = in_valid && in_ready;
  assign sum_nx = sum + in_data;
  assign {rom_we, rom_addr, rom_wdata} = {rom_we_q, rom_addr_q, rom_wdata_q};
  assign {mem_we, mem_addr, mem_wdata} = {mem_we_q, mem_addr_q, mem_wdata_q};
  assign {core_hold, done, err} = {hold_q, done_q, err_q};
  subneg_cksum #(.WIDTH(WIDTH)) u_cksum (
    .clk(clk), .rst(rst), .clr_i(clr), .en_i(acc), .d_i(in_data), .sum_o(sum)
  );
  always_comb begin
    state_d = state_q;
    fld_d = fld_q;
    cnt_d = cnt_q;
    len_d = len_q;
    a_d = a_q;
    b_d = b_q;
    rom_we_d = 1'b0;
    rom_addr_d = rom_addr_q;
    rom_wdata_d = rom_wdata_q;
    mem_we_d = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    hold_d = hold_q;
    done_d = done_q;
    err_d = err_q;
    clr = 1'b0;
    case (state_q)
      ROM_LEN: if (acc) begin
        len_d = in_data;
        fld_d = '0;
        cnt_d = '0;
        err_d = 32'(in_data) > ROM_DEPTH;
        state_d = 32'(in_data) > ROM_DEPTH ? ERR : in_data == '0 ? DATA_LEN : ROM_FIELD;
      end
      ROM_FIELD: if (acc) begin
        a_d = fld_q == 2'd0 ? in_data : a_q;
        b_d = fld_q == 2'd1 ? in_data : b_q;
        fld_d = fld_q == 2'd2 ? 2'd0 : fld_q + 2'd1;
        if (fld_q == 2'd2) begin
          // A and B were captured earlier; C comes straight off the bus
          rom_we_d = 1'b1;
          rom_addr_d = cnt_q;
          rom_wdata_d = {a_q, b_q, in_data};
          cnt_d = cnt_q + 1'b1;
          state_d = cnt_q == len_q - 1'b1 ? DATA_LEN : ROM_FIELD;
        end
      end
      DATA_LEN: if (acc) begin
        len_d = in_data;
        cnt_d = '0;
        err_d = 32'(in_data) > DATA_DEPTH;
        state_d = 32'(in_data) > DATA_DEPTH ? ERR : in_data == '0 ? CHK : DATA_WORD;
      end
      DATA_WORD: if (acc) begin
        mem_we_d = 1'b1;
        mem_addr_d = cnt_q;
        mem_wdata_d = in_data;
        cnt_d = cnt_q + 1'b1;
        state_d = cnt_q == len_q - 1'b1 ? CHK : DATA_WORD;
      end
      CHK: if (acc) begin
        done_d = sum_nx == '0;
        err_d = sum_nx != '0;
        hold_d = sum_nx != '0;
        state_d = sum_nx == '0 ? DONE : ERR;
      end
      default: if (start) begin
        state_d = ROM_LEN;
        fld_d = '0;
        cnt_d = '0;
        len_d = '0;
        done_d = 1'b0;
        err_d = 1'b0;
        hold_d = 1'b1;
        clr = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= ROM_LEN;
      fld_q <= '0;
      cnt_q <= '0;
      len_q <= '0;
      a_q <= '0;
      b_q <= '0;
      rom_we_q <= 1'b0;
      rom_addr_q <= '0;
      rom_wdata_q <= '0;
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      hold_q <= 1'b1;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fld_q <= fld_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      a_q <= a_d;
      b_q <= b_d;
      rom_we_q <= rom_we_d;
      rom_addr_q <= rom_addr_d;
      rom_wdata_q <= rom_wdata_d;
      mem_we_q <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      hold_q <= hold_d;
      done_q <= done_d;
      err_q <= err_d;
    end
endmodule
